conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Upstream feeder for the convolution systolic array.
- Accepts a raster-order, multi-channel pixel stream, one pixel per cycle from the camera path.
- Keeps F_WIDTH-1 line buffers per channel and emits one flattened F_WIDTH x F_WIDTH x CHANNEL window per valid output position, stride 1, no padding.
- The output vector drives the array's vectorized_input directly. The per-row skew is applied inside the array, so windows leave this block unskewed.

Parameters:
- CHANNEL, 2, number of input channels.
- F_WIDTH, 2, filter kernel width and height.
- I_D_SIZE, 4, bits per pixel sample.
- IMG_WIDTH, 8, pixels per line (must be >= F_WIDTH).
- IMG_HEIGHT, 8, lines per frame (must be >= F_WIDTH).
- HEIGHT (localparam), CHANNEL*F_WIDTH*F_WIDTH, number of window elements.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- clk_en  in  1  clock enable; when low, all state holds.
- pixel_i  in  [CHANNEL-1:0][I_D_SIZE-1:0]  current pixel, all channels.
- pixel_valid_i  in  1  pixel_i is valid this cycle.
- sof_i  in  1  start of frame; qualified by pixel_valid_i; marks pixel (row 0, col 0).
- vectorized_input_o  out  [HEIGHT-1:0][I_D_SIZE-1:0]  flattened window.
- window_valid_o  out  1  vectorized_input_o holds a complete window.
- frame_done_o  out  1  one-cycle pulse alongside the last window of the frame.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high. Port names are clk and rst.
- Reset values: all outputs 0; col/row counters 0; window registers 0. Line-buffer contents are don't-care and need not be reset.
- Gating: nothing changes unless clk_en=1. A pixel is accepted when clk_en=1 and pixel_valid_i=1. Idle cycles (pixel_valid_i=0) hold all state.
- Counters: col runs 0..IMG_WIDTH-1. row runs 0..IMG_HEIGHT-1.
  - Each accepted pixel increments col. On col=IMG_WIDTH-1, col wraps to 0 and row increments.
  - After (IMG_WIDTH-1, IMG_HEIGHT-1), both wrap to 0 and the next frame starts implicitly.
- sof_i: an accepted pixel with sof_i=1 is treated as position (0,0) regardless of counter state. Counters are forced so that the next pixel is (col 1, row 0). This is how a mid-frame resync is done; line-buffer contents are not cleared.
- Line buffers: per channel, F_WIDTH-1 chained delay lines of IMG_WIDTH samples.
  - Line k outputs the pixel from k lines above the current one.
  - Written only on accepted pixels.
- Window registers: per channel and per row, an F_WIDTH-deep shift register loaded on accepted pixels.
  - Row F_WIDTH-1 is loaded from pixel_i.
  - Row r<F_WIDTH-1 is loaded from line buffer (F_WIDTH-1-r).
- Window validity: valid when the accepted pixel has col>=F_WIDTH-1 and row>=F_WIDTH-1. Otherwise it is an invalid position, including the first F_WIDTH-1 columns of every line.
- Output ordering: element index = c*F_WIDTH*F_WIDTH + r*F_WIDTH + k.
  - c is the channel.
  - r is the window row; 0 is the top/oldest line.
  - k is the window column; 0 is leftmost/oldest.
- Latency: window_valid_o and vectorized_input_o update on the clock edge that accepts the completing pixel, and are visible in the following cycle (1-cycle latency).
  - window_valid_o drops to 0 on the next enabled edge unless another valid window completes.
  - vectorized_input_o holds its last value when not valid.
- frame_done_o: 1 together with the window completed by pixel (IMG_WIDTH-1, IMG_HEIGHT-1); 0 otherwise.
- Throughput: one window per accepted pixel. No backpressure; downstream must consume every cycle.
- Reset mid-frame: immediately clears valid and counters. The first pixel after reset is (0,0) whether or not sof_i is set.
- No arithmetic on pixel data: samples pass through bit-exact.

Decomposition:
- Shared package cnn_pkg holds:
  - typedef pixel_t (logic [I_D_SIZE-1:0]);
  - function win_idx(c,r,k) giving the flattened index;
  - the HEIGHT formula, so this block and the systolic array agree.
- One sub-module, line_buffer: a single-channel IMG_WIDTH-deep delay line with write enable and a circular pointer.
  - Instantiated CHANNEL*(F_WIDTH-1) times.
  - Inferable as distributed RAM.

Test Plan:
- Single frame. Config: CHANNEL=1, F_WIDTH=2, IMG_WIDTH=4, IMG_HEIGHT=3; pixel value = raster index 0..11, continuous valid, sof on pixel 0.
  - Exactly 6 windows.
  - First window appears after pixel 5, value {0,1,4,5}.
  - No valid after pixels 0-4 or after pixel 8.
  - Window after pixel 9 is {4,5,8,9}.
  - Last window {6,7,10,11} with frame_done_o=1.
- Gaps and clock enable: same frame with pixel_valid_i low every other cycle and clk_en low for 3 cycles mid-line -> identical window sequence; outputs frozen while clk_en=0.
- Two channels: CHANNEL=2, ch1 = index+8 (4-bit wrap) -> first window {0,1,4,5,8,9,12,13}; element index follows win_idx.
- Back-to-back frames without sof on frame 2 -> second frame's windows match the first; frame_done_o pulses twice, 12 accepted pixels apart.
- Resync: sof_i asserted on raster pixel 6 mid-frame -> counters restart; the next valid window appears only after 5 further pixels.
- Reset: rst asserted after pixel 7, then released -> outputs 0 immediately; replaying the frame gives the Single frame test's results.

Source files
------------

// File: rtl/cnn_pkg.sv
// Types and index helpers shared by the window generator and the systolic array,
// so both sides agree on the window size and on element placement.
package cnn_pkg;

    localparam int PIX_BITS = 4;

    typedef logic [PIX_BITS-1:0] pixel_t;

    // Number of elements in one flattened F x F x C window.
    function automatic int win_height(input int channel, input int f_width);
        return channel * f_width * f_width;
    endfunction

    // Flattened position of window element (channel c, row r, column k); row 0 and column 0 are oldest.
    function automatic int win_idx(input int c, input int r, input int k, input int f_width);
        return c * f_width * f_width + r * f_width + k;
    endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// Single-channel delay line of DEPTH accepted samples, built as a circular buffer.
// Read is asynchronous at the write pointer, so it infers as distributed RAM.
module line_buffer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;

    // The slot about to be overwritten holds the sample from DEPTH writes ago.
    assign dout_o = mem[ptr_q];

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        ptr_d = ptr_q;
        if (we_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // NOTE: storage arrays have no reset; their contents are don't-care after reset and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding F_WIDTH x F_WIDTH x CHANNEL window generator over a raster pixel stream (stride 1, no padding).
// Windows leave unskewed; F_WIDTH must be at least 2.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter  int CHANNEL    = 2,
    parameter  int F_WIDTH    = 2,
    parameter  int I_D_SIZE   = 4,
    parameter  int IMG_WIDTH  = 8,
    parameter  int IMG_HEIGHT = 8,
    localparam int HEIGHT     = win_height(CHANNEL, F_WIDTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clk_en,
    input  logic [CHANNEL-1:0][I_D_SIZE-1:0]   pixel_i,
    input  logic                               pixel_valid_i,
    input  logic                               sof_i,
    output logic [HEIGHT-1:0][I_D_SIZE-1:0]    vectorized_input_o,
    output logic                               window_valid_o,
    output logic                               frame_done_o
);

    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic                 accept;
    logic [COL_W-1:0]     col_q, col_d, cur_col;
    logic [ROW_W-1:0]     row_q, row_d, cur_row;
    logic                 pos_valid, last_pos;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;

    logic [CHANNEL-1:0][F_WIDTH-1:0][F_WIDTH-1:0][I_D_SIZE-1:0] win_q, win_d;
    logic [HEIGHT-1:0][I_D_SIZE-1:0]                             vec_q, vec_d;

    // lb_dout[c][j] is channel c's sample from j+1 lines above the incoming pixel.
    logic [I_D_SIZE-1:0] lb_dout [CHANNEL][F_WIDTH-1];

    assign accept = clk_en & pixel_valid_i;

    for (genvar c = 0; c < CHANNEL; c++) begin : g_ch
        for (genvar j = 0; j < F_WIDTH - 1; j++) begin : g_line
            logic [I_D_SIZE-1:0] din;
            if (j == 0) begin : g_first
                assign din = pixel_i[c];
            end else begin : g_chain
                assign din = lb_dout[c][j-1];
            end

            line_buffer #(
                .WIDTH (I_D_SIZE),
                .DEPTH (IMG_WIDTH)
            ) u_line_buffer (
                .clk    (clk),
                .rst    (rst),
                .we_i   (accept),
                .din_i  (din),
                .dout_o (lb_dout[c][j])
            );
        end
    end

    // Position tracking; sof_i overrides the counters so the pixel becomes (0,0).
    always_comb begin
        cur_col   = sof_i ? '0 : col_q;
        cur_row   = sof_i ? '0 : row_q;
        pos_valid = (cur_col >= COL_W'(F_WIDTH - 1)) && (cur_row >= ROW_W'(F_WIDTH - 1));
        last_pos  = (cur_col == COL_W'(IMG_WIDTH - 1)) && (cur_row == ROW_W'(IMG_HEIGHT - 1));

        col_d   = col_q;
        row_d   = row_q;
        valid_d = valid_q;
        done_d  = done_q;

        if (clk_en) begin
            valid_d = accept && pos_valid;
            done_d  = accept && pos_valid && last_pos;
        end

        if (accept) begin
            if (cur_col == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    // Shift each window row left by one column and load the newest column on the right.
    always_comb begin
        win_d = win_q;
        vec_d = vec_q;

        if (accept) begin
            for (int c = 0; c < CHANNEL; c++) begin
                for (int r = 0; r < F_WIDTH; r++) begin
                    for (int k = 0; k < F_WIDTH - 1; k++) begin
                        win_d[c][r][k] = win_q[c][r][k+1];
                    end
                end
                for (int r = 0; r < F_WIDTH - 1; r++) begin
                    win_d[c][r][F_WIDTH-1] = lb_dout[c][F_WIDTH-2-r];
                end
                win_d[c][F_WIDTH-1][F_WIDTH-1] = pixel_i[c];
            end

            if (pos_valid) begin
                for (int c = 0; c < CHANNEL; c++) begin
                    for (int r = 0; r < F_WIDTH; r++) begin
                        for (int k = 0; k < F_WIDTH; k++) begin
                            vec_d[win_idx(c, r, k, F_WIDTH)] = win_d[c][r][k];
                        end
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            win_q   <= '0;
            vec_q   <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            win_q   <= win_d;
            vec_q   <= vec_d;
        end
    end

    assign vectorized_input_o = vec_q;
    assign window_valid_o     = valid_q;
    assign frame_done_o       = done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x3, two-channel, 2x2-window configuration.
// Channel 0 carries the raster index, channel 1 carries index+8 (4-bit wrap).
module tb_conv_window_gen;

    localparam int CH = 2;
    localparam int FW = 2;
    localparam int ID = 4;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HT = CH * FW * FW;

    typedef logic [HT-1:0][ID-1:0] win_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               clk_en;
    logic [CH-1:0][ID-1:0] pixel_i;
    logic               pixel_valid_i;
    logic               sof_i;
    win_t               vec;
    logic               wvalid;
    logic               fdone;

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int done_at[$];

    always #5 clk = ~clk;

    conv_window_gen #(
        .CHANNEL    (CH),
        .F_WIDTH    (FW),
        .I_D_SIZE   (ID),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .clk_en             (clk_en),
        .pixel_i            (pixel_i),
        .pixel_valid_i      (pixel_valid_i),
        .sof_i              (sof_i),
        .vectorized_input_o (vec),
        .window_valid_o     (wvalid),
        .frame_done_o       (fdone)
    );

    // Window completed by raster pixel p (p in the valid region): rows {p-5,p-4} over {p-1,p}.
    function automatic win_t exp_win(input int p);
        win_t w;
        int   src [4];
        src = '{p - 5, p - 4, p - 1, p};
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < 4; i++) begin
                w[c*4+i] = 4'(src[i] + c * 8);
            end
        end
        return w;
    endfunction

    task automatic drive(input bit en, input bit vld, input bit sof, input int val);
        clk_en        = en;
        pixel_valid_i = vld;
        sof_i         = sof;
        pixel_i[0]    = 4'(val);
        pixel_i[1]    = 4'(val + 8);
        @(posedge clk);
        #1;
        if (en && vld) acc_cnt++;
    endtask

    task automatic play_frame(input string tag, input bit use_sof, output int windows);
        windows = 0;
        for (int p = 0; p < W * H; p++) begin
            bit exp_v;
            drive(1'b1, 1'b1, use_sof && (p == 0), p);
            exp_v = ((p % W) >= 1) && ((p / W) >= 1);
            if (wvalid === 1'b1) windows++;
            if (fdone === 1'b1) done_at.push_back(acc_cnt);
            n_checks++;
            if (wvalid !== exp_v) begin
                n_fail++;
                $display("FAIL %s valid p=%0d got %b want %b", tag, p, wvalid, exp_v);
            end
            n_checks++;
            if (fdone !== (p == W * H - 1)) begin
                n_fail++;
                $display("FAIL %s frame_done p=%0d got %b want %b", tag, p, fdone, (p == W * H - 1));
            end
            if (exp_v) begin
                n_checks++;
                if (vec !== exp_win(p)) begin
                    n_fail++;
                    $display("FAIL %s window p=%0d got %h want %h", tag, p, vec, exp_win(p));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        clk_en        = 1'b0;
        pixel_valid_i = 1'b0;
        sof_i         = 1'b0;
        pixel_i       = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (wvalid !== 1'b0) begin n_fail++; $display("FAIL reset valid got %b want 0", wvalid); end
        n_checks++;
        if (fdone !== 1'b0) begin n_fail++; $display("FAIL reset frame_done got %b want 0", fdone); end
        n_checks++;
        if (vec !== '0) begin n_fail++; $display("FAIL reset window got %h want 0", vec); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_frame();
        int windows;
        play_frame("single", 1'b1, windows);
        n_checks++;
        if (windows != 6) begin n_fail++; $display("FAIL single window_count got %0d want 6", windows); end
    endtask

    task automatic test_gaps_clken();
        int   windows = 0;
        int   last_p  = 11;
        for (int p = 0; p < W * H; p++) begin
            bit exp_v;
            drive(1'b1, 1'b1, p == 0, p);
            exp_v = ((p % W) >= 1) && ((p / W) >= 1);
            if (wvalid === 1'b1) windows++;
            n_checks++;
            if (wvalid !== exp_v) begin
                n_fail++;
                $display("FAIL gaps valid p=%0d got %b want %b", p, wvalid, exp_v);
            end
            if (exp_v) begin
                last_p = p;
                n_checks++;
                if (vec !== exp_win(p)) begin
                    n_fail++;
                    $display("FAIL gaps window p=%0d got %h want %h", p, vec, exp_win(p));
                end
            end
            if (p == 6) begin
                // Pixels offered while disabled must be ignored and outputs must freeze.
                for (int i = 0; i < 3; i++) begin
                    drive(1'b0, 1'b1, 1'b1, 13);
                    n_checks++;
                    if (wvalid !== 1'b1 || vec !== exp_win(6)) begin
                        n_fail++;
                        $display("FAIL clken_freeze i=%0d got valid=%b win=%h want valid=1 win=%h",
                                 i, wvalid, vec, exp_win(6));
                    end
                end
            end
            drive(1'b1, 1'b0, 1'b0, 9);
            n_checks++;
            if (wvalid !== 1'b0 || fdone !== 1'b0) begin
                n_fail++;
                $display("FAIL gaps idle p=%0d got valid=%b done=%b want 0 0", p, wvalid, fdone);
            end
            if (p >= 5) begin
                n_checks++;
                if (vec !== exp_win(last_p)) begin
                    n_fail++;
                    $display("FAIL gaps hold p=%0d got %h want %h", p, vec, exp_win(last_p));
                end
            end
        end
        n_checks++;
        if (windows != 6) begin n_fail++; $display("FAIL gaps window_count got %0d want 6", windows); end
    endtask

    task automatic test_two_channels();
        int exp_e [8] = '{0, 1, 4, 5, 8, 9, 12, 13};
        for (int p = 0; p < 6; p++) drive(1'b1, 1'b1, p == 0, p);
        for (int i = 0; i < HT; i++) begin
            n_checks++;
            if (vec[i] !== 4'(exp_e[i])) begin
                n_fail++;
                $display("FAIL two_ch element %0d got %0d want %0d", i, vec[i], exp_e[i]);
            end
        end
        for (int p = 6; p < W * H; p++) drive(1'b1, 1'b1, 1'b0, p);
    endtask

    task automatic test_back_to_back();
        int windows;
        done_at.delete();
        play_frame("b2b_f1", 1'b1, windows);
        play_frame("b2b_f2", 1'b0, windows);
        n_checks++;
        if (windows != 6) begin n_fail++; $display("FAIL b2b window_count got %0d want 6", windows); end
        n_checks++;
        if (done_at.size() != 2) begin
            n_fail++;
            $display("FAIL b2b done_pulses got %0d want 2", done_at.size());
        end else begin
            n_checks++;
            if (done_at[1] - done_at[0] != 12) begin
                n_fail++;
                $display("FAIL b2b done_spacing got %0d want 12", done_at[1] - done_at[0]);
            end
        end
    endtask

    task automatic test_resync();
        for (int p = 0; p < 6; p++) drive(1'b1, 1'b1, p == 0, p);
        n_checks++;
        if (wvalid !== 1'b1) begin n_fail++; $display("FAIL resync pre valid got %b want 1", wvalid); end
        // Raster pixel 6 would complete a window, but sof makes it (0,0).
        for (int v = 6; v < 11; v++) begin
            drive(1'b1, 1'b1, v == 6, v);
            n_checks++;
            if (wvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL resync early value=%0d got %b want 0", v, wvalid);
            end
        end
        drive(1'b1, 1'b1, 1'b0, 11);
        n_checks++;
        if (wvalid !== 1'b1 || fdone !== 1'b0) begin
            n_fail++;
            $display("FAIL resync first got valid=%b done=%b want 1 0", wvalid, fdone);
        end
        n_checks++;
        if (vec !== exp_win(11)) begin
            n_fail++;
            $display("FAIL resync window got %h want %h", vec, exp_win(11));
        end
    endtask

    task automatic test_reset_midframe();
        int windows;
        for (int p = 0; p < 8; p++) drive(1'b1, 1'b1, p == 0, p);
        n_checks++;
        if (wvalid !== 1'b1) begin n_fail++; $display("FAIL midrst pre valid got %b want 1", wvalid); end
        clk_en        = 1'b0;
        pixel_valid_i = 1'b0;
        sof_i         = 1'b0;
        rst           = 1'b1;
        #2;
        n_checks++;
        if (wvalid !== 1'b0 || fdone !== 1'b0 || vec !== '0) begin
            n_fail++;
            $display("FAIL midrst async got valid=%b done=%b win=%h want 0 0 0", wvalid, fdone, vec);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        play_frame("after_reset", 1'b0, windows);
        n_checks++;
        if (windows != 6) begin n_fail++; $display("FAIL after_reset window_count got %0d want 6", windows); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gaps_clken();
        test_two_channels();
        test_back_to_back();
        test_resync();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
